// File: rtl/router_in_buf.sv
// Router input-port flit buffer: first-word fall-through circular FIFO drained
// only in the scheduler phase owned by this port, with a sticky overflow flag.
module router_in_buf #(
    parameter int         DEPTH   = 4,
    parameter logic [1:0] PORT_ID = 2'b00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [17:0]                in_flit,
    output logic                       in_ready,
    input  logic [1:0]                 phase,
    output logic [17:0]                out_flit,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [17:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;

    // Ready looks only at the registered occupancy, so a full buffer rejects
    // a flit even on the edge where it also pops.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (phase == PORT_ID) && (count_q != '0);
    assign out_valid = (count_q != '0);
    assign out_flit  = out_valid ? mem_q[rd_ptr_q] : 18'h0;
    assign count     = count_q;
    assign ovf       = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (in_valid && !in_ready) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_flit;
    end

endmodule

// File: tb/tb_router_in_buf.sv
// Scoreboard bench for router_in_buf: a queue model predicts every pop and the
// full visible state after each edge.
module tb_router_in_buf;
    localparam int         DEPTH   = 4;
    localparam logic [1:0] PORT_ID = 2'b01;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [17:0] in_flit;
    logic        in_ready;
    logic [1:0]  phase;
    logic [17:0] out_flit;
    logic        out_valid;
    logic [$clog2(DEPTH):0] count;
    logic        ovf;

    logic [17:0] sb_q[$];
    bit          exp_ovf;
    int          n_chk  = 0;
    int          n_fail = 0;

    router_in_buf #(.DEPTH(DEPTH), .PORT_ID(PORT_ID)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
        .in_ready(in_ready), .phase(phase), .out_flit(out_flit),
        .out_valid(out_valid), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"},     32'(count),     32'(sb_q.size()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(sb_q.size() != 0));
        chk({tag, ".out_flit"},  32'(out_flit),  (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'h0);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(sb_q.size() < DEPTH));
        chk({tag, ".ovf"},       32'(ovf),       32'(exp_ovf));
    endtask

    // One clock: drive after the falling edge, compare any popped flit before the
    // rising edge, then update the model and check state just after it.
    task automatic step(input logic v, input logic [17:0] f, input logic [1:0] ph,
                        input string tag, output bit acc);
        bit          pop;
        logic [17:0] e;
        @(negedge clk);
        in_valid = v; in_flit = f; phase = ph;
        acc = v && (sb_q.size() < DEPTH);
        pop = (ph == PORT_ID) && (sb_q.size() != 0);
        if (pop) begin
            e = sb_q.pop_front();
            chk({tag, ".pop_flit"}, 32'(out_flit), 32'(e));
        end
        @(posedge clk);
        if (acc) sb_q.push_back(f);
        if (v && !acc) exp_ovf = 1'b1;
        #1 chk_state(tag);
    endtask

    initial begin
        bit acc;
        int sent, cyc;
        rst = 1'b0; in_valid = 1'b0; in_flit = '0; phase = 2'b00; exp_ovf = 1'b0;
        #1 chk_state("reset");
        @(negedge clk); rst = 1'b1;

        // Single flit: visible after push edge, consumed on phase 01 edge
        step(1'b1, 18'h2C3FF, 2'b00, "single_push", acc);
        step(1'b0, 18'h0,     2'b01, "single_pop",  acc);
        step(1'b0, 18'h0,     2'b10, "single_idle", acc);

        // Empty pops across all phases
        for (int i = 0; i < 8; i++) step(1'b0, 18'h0, 2'(i), "empty_pop", acc);
        step(1'b1, 18'h0ABCD, 2'b00, "after_empty", acc);
        step(1'b0, 18'h0,     2'b01, "after_empty_pop", acc);

        // Fill and overflow with phase never matching
        for (int i = 1; i <= 5; i++) step(1'b1, 18'(32'h10 + i), 2'b00, "fill", acc);

        // Full with simultaneous pop: push rejected, then accepted next edge
        step(1'b1, 18'h00016, 2'b01, "full_pop", acc);
        step(1'b1, 18'h00016, 2'b10, "full_retry", acc);
        step(1'b0, 18'h0,     2'b01, "pre_reset_pop", acc);

        // Async reset between edges with three queued flits
        #2 rst = 1'b0;
        #1;
        sb_q.delete(); exp_ovf = 1'b0;
        chk_state("async_reset");
        @(negedge clk); rst = 1'b1;
        step(1'b1, 18'h3A5A5, 2'b00, "post_reset_push", acc);
        step(1'b0, 18'h0,     2'b01, "post_reset_pop",  acc);

        // Wrap and order: stream 10 flits with a rotating phase
        sent = 0; cyc = 0;
        while ((sent < 10 || sb_q.size() != 0) && cyc < 200) begin
            step(sent < 10, 18'(sent + 1), 2'(cyc), "stream", acc);
            if (acc) sent++;
            cyc++;
        end
        chk("stream.bound", 32'(cyc < 200), 32'd1);
        chk("stream.sent",  32'(sent), 32'd10);

        @(negedge clk); in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
